// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the fpdiv round/pack stage.
package fpdiv_pkg;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'b00,
    EXC_UNDER   = 2'b01,
    EXC_OVER    = 2'b10,
    EXC_INVALID = 2'b11
  } exc_e;

  function automatic logic [31:0] pack_word(input logic       sign,
                                            input logic [7:0] field,
                                            input logic [22:0] frac);
    return {sign, field, frac};
  endfunction

endpackage

// File: rtl/fpdiv_round_pack_if.sv
// Input (normalised quotient) and output (packed result) channels of fpdiv_round_pack.
interface fpdiv_round_pack_if #(
  parameter int UEXP_W = 10,
  parameter int FRAC_W = 23
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [UEXP_W-1:0] in_exp;
  logic [FRAC_W+2:0] in_mant;
  logic              in_sticky;
  logic              in_special;
  logic [31:0]       in_special_word;
  logic [1:0]        in_special_exc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [1:0]        out_exc;
  logic              out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky,
           in_special, in_special_word, in_special_exc, out_ready,
    input  in_ready, out_valid, out_word, out_exc, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_sticky,
           in_special, in_special_word, in_special_exc, out_ready,
    output in_ready, out_valid, out_word, out_exc, out_inexact
  );
endinterface

// File: rtl/fpdiv_rne_round.sv
// Round-to-nearest-even of a 1.f mantissa with guard/round/sticky; handles
// carry-out into the exponent and subnormal-to-normal promotion.
module fpdiv_rne_round
  import fpdiv_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [FRAC_W+2:0] mant,
  input  logic              sticky,
  input  logic [EXP_W-1:0]  field_in,
  output logic [FRAC_W-1:0] frac,
  output logic [EXP_W-1:0]  field_out,
  output logic              inexact,
  output logic              overflow
);
  logic              lsb, g, r, inc;
  logic [FRAC_W+1:0] sum;
  logic [EXP_W:0]    field_inc;

  assign lsb       = mant[2];
  assign g         = mant[1];
  assign r         = mant[0];
  assign inc       = g & (r | sticky | lsb);
  assign sum       = {1'b0, mant[FRAC_W+2:2]} + {{(FRAC_W+1){1'b0}}, inc};
  assign inexact   = g | r | sticky;
  assign field_inc = {1'b0, field_in} + {{EXP_W{1'b0}}, 1'b1};

  always_comb begin
    frac      = sum[FRAC_W-1:0];
    field_out = field_in;
    overflow  = 1'b0;
    if (sum[FRAC_W+1]) begin
      // Mantissa rolled over to 2.0: renormalise by one and bump the exponent.
      frac      = sum[FRAC_W:1];
      field_out = field_inc[EXP_W-1:0];
      overflow  = (field_inc >= (EXP_W+1)'(EXP_MAX));
    end else if (field_in == '0 && sum[FRAC_W]) begin
      field_out = EXP_W'(1);
    end
  end
endmodule

// File: rtl/fpdiv_round_pack.sv
// fpdiv final stage: RNE rounding, iterative denormalisation and IEEE-754 packing.
// Define FPDIV_RP_FTZ_EN to flush subnormal results to zero instead of shifting.
module fpdiv_round_pack
  import fpdiv_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int UEXP_W = 10,
  parameter int BIAS   = fpdiv_pkg::BIAS
) (
  input logic          CLOCK,
  input logic          RESET_N,
  fpdiv_round_pack_if.slave bus
);
  localparam int CNT_W = $clog2(FRAC_W + 3);
  localparam logic signed [UEXP_W:0] BIAS_S    = (UEXP_W+1)'(BIAS);
  localparam logic signed [UEXP_W:0] EXP_MAX_S = (UEXP_W+1)'(EXP_MAX);
  localparam logic signed [UEXP_W:0] ONE_S     = (UEXP_W+1)'(1);
  localparam logic signed [UEXP_W:0] DEEP_S    = (UEXP_W+1)'(1 - (FRAC_W + 2));

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [FRAC_W+2:0]   mant_q, mant_d;
  logic                sticky_q, sticky_d;
  logic [EXP_W-1:0]    field_q, field_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         word_q, word_d;
  exc_e                exc_q, exc_d;
  logic                inexact_q, inexact_d;

  logic signed [UEXP_W:0] be, shift_amt;
  logic [FRAC_W-1:0]   rnd_frac;
  logic [EXP_W-1:0]    rnd_field;
  logic                rnd_inexact, rnd_overflow;

  assign be        = $signed({bus.in_exp[UEXP_W-1], bus.in_exp}) + BIAS_S;
  assign shift_amt = ONE_S - be;

  fpdiv_rne_round #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
    .mant      (mant_q),
    .sticky    (sticky_q),
    .field_in  (field_q),
    .frac      (rnd_frac),
    .field_out (rnd_field),
    .inexact   (rnd_inexact),
    .overflow  (rnd_overflow)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    sign_d    = sign_q;
    mant_d    = mant_q;
    sticky_d  = sticky_q;
    field_d   = field_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    exc_d     = exc_q;
    inexact_d = inexact_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        sign_d   = bus.in_sign;
        mant_d   = bus.in_mant;
        sticky_d = bus.in_sticky;
        if (bus.in_special) begin
          word_d    = bus.in_special_word;
          exc_d     = exc_e'(bus.in_special_exc);
          inexact_d = 1'b0;
          state_d   = HOLD;
        end else if (be >= EXP_MAX_S) begin
          word_d    = INF | {bus.in_sign, 31'd0};
          exc_d     = EXC_OVER;
          inexact_d = 1'b1;
          state_d   = HOLD;
        end else if (be >= ONE_S) begin
          field_d = be[EXP_W-1:0];
          state_d = ROUND;
`ifdef FPDIV_RP_FTZ_EN
        end else begin
          word_d    = {bus.in_sign, 31'd0};
          exc_d     = EXC_UNDER;
          inexact_d = 1'b1;
          state_d   = HOLD;
        end
`else
        end else if (be < DEEP_S) begin
          // Every significant bit would be shifted past the round position.
          word_d    = {bus.in_sign, 31'd0};
          exc_d     = EXC_UNDER;
          inexact_d = 1'b1;
          state_d   = HOLD;
        end else begin
          field_d = '0;
          cnt_d   = shift_amt[CNT_W-1:0];
          state_d = SHIFT;
        end
`endif
      end
      SHIFT: begin
        mant_d   = mant_q >> 1;
        sticky_d = sticky_q | mant_q[0];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ROUND;
      end
      ROUND: begin
        inexact_d = rnd_inexact;
        if (rnd_overflow) begin
          word_d = INF | {sign_q, 31'd0};
          exc_d  = EXC_OVER;
        end else begin
          word_d = pack_word(sign_q, rnd_field, rnd_frac);
          exc_d  = (rnd_field == '0 && rnd_inexact) ? EXC_UNDER : EXC_NONE;
        end
        state_d = HOLD;
      end
      HOLD: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mant_q    <= '0;
      sticky_q  <= 1'b0;
      field_q   <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      exc_q     <= EXC_NONE;
      inexact_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      state_q   <= state_d;
      sign_q    <= sign_d;
      mant_q    <= mant_d;
      sticky_q  <= sticky_d;
      field_q   <= field_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      exc_q     <= exc_d;
      inexact_q <= inexact_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == HOLD);
  assign bus.out_word    = word_q;
  assign bus.out_exc     = exc_q;
  assign bus.out_inexact = inexact_q;
endmodule

// File: tb/tb_fpdiv_round_pack.sv
// Randomised bench for fpdiv_round_pack against an exact-arithmetic RNE model,
// plus directed corner vectors, stall/handshake and mid-operation reset.
module tb_fpdiv_round_pack;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpdiv_round_pack_if bus ();

  fpdiv_round_pack dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] last_word;
  logic [1:0]  last_exc;
  logic        last_inex;
  int          last_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: treat the quotient as an exact integer and round it to the
  // quantum of the target format, then use the integer-add packing identity.
  function automatic void model(input logic sign, input int e, input logic [25:0] mant,
                                input logic sticky, output logic [31:0] word,
                                output logic [1:0] exc, output logic inex, output int lat);
    int     be, k;
    longint keep, d, half, q, pk;
    logic   up;
    be = e + 127;
    if (be >= 255) begin
      word = {sign, 8'hFF, 23'd0}; exc = 2'b10; inex = 1'b1; lat = 1;
      return;
    end
    k = (be >= 1) ? 0 : 1 - be;
`ifdef FPDIV_RP_FTZ_EN
    if (be <= 0) begin
`else
    if (k > 25) begin
`endif
      word = {sign, 31'd0}; exc = 2'b01; inex = 1'b1; lat = 1;
      return;
    end
    keep = longint'(mant) >> (k + 2);
    d    = longint'(mant) & ((64'sd1 <<< (k + 2)) - 1);
    half = 64'sd1 <<< (k + 1);
    up   = (d > half) || (d == half && (sticky || (keep % 2 == 1)));
    inex = (d != 0) || sticky;
    q    = keep + (up ? 1 : 0);
    pk   = (be >= 1) ? ((longint'(be - 1) <<< 23) + q) : q;
    lat  = 2 + k;
    if (pk >= (longint'(255) <<< 23)) begin
      word = {sign, 8'hFF, 23'd0}; exc = 2'b10; inex = 1'b1;
    end else begin
      word = {sign, pk[30:0]};
      exc  = (pk < (64'sd1 <<< 23) && inex) ? 2'b01 : 2'b00;
    end
  endfunction

  task automatic run_op(input logic sign, input int e, input logic [25:0] mant,
                        input logic sticky, input logic special,
                        input logic [31:0] sw, input logic [1:0] sexc);
    logic [31:0] ew;
    logic [1:0]  ee;
    logic        ei;
    int          el, lat;
    if (special) begin
      ew = sw; ee = sexc; ei = 1'b0; el = 1;
    end else begin
      model(sign, e, mant, sticky, ew, ee, ei, el);
    end
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid        = 1'b1;
    bus.in_sign         = sign;
    bus.in_exp          = e[9:0];
    bus.in_mant         = mant;
    bus.in_sticky       = sticky;
    bus.in_special      = special;
    bus.in_special_word = sw;
    bus.in_special_exc  = sexc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid", bus.out_valid, 1);
    check("word", bus.out_word, ew);
    check("exc", bus.out_exc, ee);
    check("inexact", bus.out_inexact, ei);
    check("latency", lat, el);
    check("in_ready_busy", bus.in_ready, 0);
    last_word = bus.out_word; last_exc = bus.out_exc;
    last_inex = bus.out_inexact; last_lat = lat;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_released", bus.out_valid, 0);
  endtask

  initial begin
    logic [25:0] m;
    int          e, sel;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
    bus.in_sticky = 1'b0; bus.in_special = 1'b0; bus.in_special_word = '0;
    bus.in_special_exc = '0; bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_word", bus.out_word, 0);
    check("rst_out_exc", bus.out_exc, 0);
    check("rst_out_inexact", bus.out_inexact, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", bus.in_ready, 1);

    run_op(1'b0, 0, 26'h2000000, 1'b0, 1'b0, '0, '0);
    check("t1_word", last_word, 32'h3F80_0000);
    check("t1_exc", last_exc, 2'b00);
    check("t1_inex", last_inex, 1'b0);
    check("t1_lat", last_lat, 2);
    run_op(1'b0, 0, 26'h2000002, 1'b0, 1'b0, '0, '0);
    check("t2a_word", last_word, 32'h3F80_0000);
    check("t2a_inex", last_inex, 1'b1);
    run_op(1'b0, 0, 26'h2000006, 1'b0, 1'b0, '0, '0);
    check("t2b_word", last_word, 32'h3F80_0002);
    check("t2b_inex", last_inex, 1'b1);
    run_op(1'b0, 127, 26'h3FFFFFF, 1'b0, 1'b0, '0, '0);
    check("t3_word", last_word, 32'h7F80_0000);
    check("t3_exc", last_exc, 2'b10);
    run_op(1'b0, -127, 26'h2000000, 1'b0, 1'b0, '0, '0);
`ifdef FPDIV_RP_FTZ_EN
    check("t4_word", last_word, 32'h0000_0000);
    check("t4_exc", last_exc, 2'b01);
    check("t4_lat", last_lat, 1);
`else
    check("t4_word", last_word, 32'h0040_0000);
    check("t4_exc", last_exc, 2'b00);
    check("t4_lat", last_lat, 3);
`endif
    run_op(1'b1, -200, 26'h2345678, 1'b0, 1'b0, '0, '0);
    check("t5_word", last_word, 32'h8000_0000);
    check("t5_exc", last_exc, 2'b01);
    check("t5_inex", last_inex, 1'b1);
    check("t5_lat", last_lat, 1);
    run_op(1'b0, 0, 26'h2000000, 1'b0, 1'b1, 32'h7FC0_0000, 2'b11);
    check("special_word", last_word, 32'h7FC0_0000);

    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 5));
      m = {1'b1, 25'($urandom)};
      if ($urandom_range(0, 3) == 0) m[1:0] = 2'b10;
      case (sel)
        0: e = int'($urandom_range(0, 20)) - 10;
        1: e = int'($urandom_range(0, 30)) - 150;
        2: e = int'($urandom_range(0, 30)) + 100;
        3: e = int'($urandom_range(0, 11)) - 160;
        default: e = int'($urandom_range(0, 1023)) - 512;
      endcase
      run_op(1'($urandom), e, m, 1'($urandom_range(0, 3) == 0), sel == 5,
             $urandom, 2'($urandom));
    end

    // Stall in HOLD with a competing request; it must be taken one cycle after release.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_special = 1'b0; bus.in_sign = 1'b0;
    bus.in_exp = 10'd0; bus.in_mant = 26'h2000006; bus.in_sticky = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("stall_valid", bus.out_valid, 1);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_special = 1'b1;
    bus.in_special_word = 32'hFF80_0000; bus.in_special_exc = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_word", bus.out_word, 32'h3F80_0002);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_in_ready", bus.in_ready, 1);
    check("release_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_special = 1'b0;
    check("after_release_valid", bus.out_valid, 1);
    check("after_release_word", bus.out_word, 32'hFF80_0000);
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset asserted while denormalising must abandon the operation at once.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_exp = 10'(-147); bus.in_mant = 26'h2000000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_word", bus.out_word, 0);
    check("midrst_out_exc", bus.out_exc, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_idle_valid", bus.out_valid, 0);
    run_op(1'b0, 0, 26'h2000000, 1'b0, 1'b0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
